systolic_feed_ctrl: RTL

Controller that sequences a bank of ROWS 8-bit row FIFOs feeding the systolic array's input edge. Per tile it clears the FIFOs, loads burst_len words per row from a single handshaked source stream, and then drains the rows with a one-cycle-per-row skew so that data enters the array diagonally. The block drives only FIFO control strobes and valid flags; the 8-bit data is broadcast externally to every FIFO's dataIn.

---
 rtl/feed_pkg.sv | 20 ++
 rtl/skew_gen.sv | 29 ++
 rtl/systolic_feed_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/feed_pkg.sv
// Shared types and sizing helpers for the systolic feed controller.
package feed_pkg;

    localparam int MAX_BURST_DEF = 7;
    localparam int BURST_W       = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_DRAIN,
        S_FLUSH,
        S_DONE
    } state_t;

    function automatic int drain_w(input int rows, input int max_burst);
        return $clog2(rows + max_burst);
    endfunction

endpackage

// File: rtl/skew_gen.sv
// Diagonal read-strobe generator: row i reads while i <= d < i+L.
module skew_gen
    import feed_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int DW   = 4
) (
    input  logic [DW-1:0]      d,
    input  logic [BURST_W-1:0] l,
    output logic [ROWS-1:0]    rd,
    output logic               last
);

    logic [DW:0] dx;
    logic [DW:0] lx;

    assign dx = {1'b0, d};
    assign lx = (DW+1)'(l);

    always_comb begin
        rd = '0;
        for (int i = 0; i < ROWS; i++) begin
            rd[i] = (dx >= (DW+1)'(i)) && (dx < (DW+1)'(i) + lx);
        end
    end

    assign last = (dx == (DW+1)'(ROWS - 2) + lx);

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Row-FIFO sequencer for the systolic array input edge: clear, load, skewed drain.
// Optional FEED_STALL_EN adds a sink_stall input that freezes the drain.
module systolic_feed_ctrl
    import feed_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               src_valid,
    output logic               src_ready,
`ifdef FEED_STALL_EN
    input  logic               sink_stall,
`endif
    output logic               fifo_en,
    output logic               fifo_reset,
    output logic [ROWS-1:0]    fifo_wr,
    output logic [ROWS-1:0]    fifo_rd,
    input  logic [ROWS-1:0]    fifo_full,
    input  logic [ROWS-1:0]    fifo_empty,
    output logic [ROWS-1:0]    out_valid,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int DW = drain_w(ROWS, MAX_BURST);
    localparam int RW = (ROWS > 2) ? $clog2(ROWS) : 1;

    state_t             state, state_n;
    logic [BURST_W-1:0] l_q, l_in;
    logic [BURST_W-1:0] beat_q;
    logic [RW-1:0]      row_q;
    logic [DW-1:0]      d_q;
    logic [ROWS-1:0]    ov_q;
    logic               err_q;
    logic               stall;
    logic               accept;
    logic               beat_last;
    logic               viol;
    logic [ROWS-1:0]    skew_rd;
    logic               skew_last;

`ifdef FEED_STALL_EN
    assign stall = sink_stall;
`else
    assign stall = 1'b0;
`endif

    assign l_in = (burst_len > BURST_W'(MAX_BURST)) ?
                  BURST_W'(MAX_BURST) : burst_len;

    assign accept    = (state == S_IDLE) && start;
    assign beat_last = (beat_q == l_q - BURST_W'(1));
    assign viol      = |(fifo_wr & fifo_full) | |(fifo_rd & fifo_empty);

    skew_gen #(
        .ROWS (ROWS),
        .DW   (DW)
    ) u_skew (
        .d    (d_q),
        .l    (l_q),
        .rd   (skew_rd),
        .last (skew_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        src_ready  = 1'b0;
        fifo_en    = (state != S_IDLE);
        fifo_reset = 1'b0;
        fifo_wr    = '0;
        fifo_rd    = '0;
        case (state)
            S_IDLE: begin
                if (start) state_n = S_CLEAR;
            end
            S_CLEAR: begin
                fifo_reset = 1'b1;
                state_n    = (l_q == '0) ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                src_ready = 1'b1;
                if (src_valid) begin
                    fifo_wr[row_q] = 1'b1;
                    if (beat_last && row_q == RW'(ROWS - 1))
                        state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!stall) begin
                    fifo_rd = skew_rd;
                    if (skew_last) state_n = S_FLUSH;
                end
            end
            S_FLUSH: state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l_q    <= '0;
            beat_q <= '0;
            row_q  <= '0;
            d_q    <= '0;
            ov_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            ov_q <= fifo_rd;
            if (accept) begin
                l_q    <= l_in;
                beat_q <= '0;
                row_q  <= '0;
                d_q    <= '0;
                err_q  <= 1'b0;
            end else if (viol) begin
                err_q <= 1'b1;
            end
            // row-major fill: advance row after L beats
            if (state == S_LOAD && src_valid) begin
                if (beat_last) begin
                    beat_q <= '0;
                    row_q  <= row_q + RW'(1);
                end else begin
                    beat_q <= beat_q + BURST_W'(1);
                end
            end
            if (state == S_DRAIN && !stall) begin
                d_q <= d_q + DW'(1);
            end
        end
    end

    assign out_valid = ov_q;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign err       = err_q;

endmodule
